// File: rtl/paquetes_pkg.sv
// paquetes_pkg: shared types and helpers for the packet processor
package paquetes_pkg;
  typedef enum logic [1:0] {REPOSO, ESPERA, INICIO} estado_tx_t;
  function automatic int ancho_paquete(input int ancho_id, input int ancho_carga);
    return ancho_id + ancho_carga;
  endfunction
  function automatic logic [31:0] id_difusion(input int ancho_id);
    return (32'd1 << ancho_id) - 32'd1;
  endfunction
endpackage

// File: rtl/procesador_paquetes_n_cola.sv
// cola_reenvio: synchronous FIFO holding {packet, link mask} entries to forward
module cola_reenvio #(
  parameter int ANCHO = 11,
  parameter int PROFUNDIDAD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [ANCHO-1:0] dato,
  output logic [ANCHO-1:0] cabeza,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(PROFUNDIDAD);
  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign cabeza = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) begin
        mem[wr[AW-1:0]] <= dato;
        wr <= wr + (AW+1)'(1);
      end
      if (pop && !empty) rd <= rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/procesador_paquetes_n.sv
// procesador_paquetes_n: consumes local/broadcast packets, forwards the rest to the other links
module procesador_paquetes_n import paquetes_pkg::*; #(
  parameter int NUM_CANALES = 3,
  parameter int ANCHO_ID = 4,
  parameter int ANCHO_CARGA = 4,
  parameter int PROFUNDIDAD_COLA = 4,
  parameter int ANCHO_CONTADOR = 8,
  localparam int ANCHO_PAQUETE = ancho_paquete(ANCHO_ID, ANCHO_CARGA)
) (
  input  logic                                 reloj,
  input  logic                                 reinicio,
  input  logic [ANCHO_ID-1:0]                  identificadorFPGA,
  input  logic [NUM_CANALES-1:0]               recepcionFinalizada,
  input  logic [NUM_CANALES*ANCHO_PAQUETE-1:0] datoRecibido,
  input  logic [NUM_CANALES-1:0]               transmisorOcupado,
  output logic [NUM_CANALES-1:0]               iniciarTransmision,
  output logic [ANCHO_PAQUETE-1:0]             datoTransmitir,
  output logic [ANCHO_CARGA-1:0]               datoConsumido,
  output logic                                 datoConsumidoValido,
  output logic [ANCHO_CONTADOR-1:0]            cantidadContadorPaquetes,
  output logic [ANCHO_CONTADOR-1:0]            cantidadContadorPaquetesProcesados,
  output logic [ANCHO_CONTADOR-1:0]            cantidadContadorPaquetesDescartados,
  output logic                                 colaLlena
);
  localparam int N = NUM_CANALES;
  localparam int AP = ANCHO_PAQUETE;
  localparam int PW = $clog2(N);
  localparam int MAXC = (1 << ANCHO_CONTADOR) - 1;
  localparam logic [ANCHO_ID-1:0] DIFUSION = ANCHO_ID'(id_difusion(ANCHO_ID));
  function automatic logic [PW-1:0] rota(input logic [PW-1:0] p, input int j);
    int s = int'(p) + j;
    return PW'(s >= N ? s - N : s);
  endfunction
  function automatic logic [ANCHO_CONTADOR-1:0] sat(input logic [ANCHO_CONTADOR-1:0] v, input int n);
    return int'(v) + n > MAXC ? '1 : ANCHO_CONTADOR'(int'(v) + n);
  endfunction
  logic [N-1:0] pendiente, sobre, mascara_push, mascara;
  logic [AP-1:0] pend_dato [N];
  logic [PW-1:0] ptr, idx;
  logic concedido, consumir, reenviar, push, pop, vacia;
  logic [AP-1:0] paq;
  logic [ANCHO_ID-1:0] dst;
  logic [AP+N-1:0] cabeza;
  estado_tx_t estado, estado_sig;
  // Lowest rotation offset from the pointer wins, so scan backwards and keep the last hit
  always_comb begin
    idx = '0;
    concedido = 1'b0;
    for (int j = N - 1; j >= 0; j--)
      if (pendiente[rota(ptr, j)]) begin
        concedido = 1'b1;
        idx = rota(ptr, j);
      end
    for (int i = 0; i < N; i++)
      sobre[i] = recepcionFinalizada[i] && pendiente[i] && !(concedido && idx == PW'(i));
  end
  assign paq = pend_dato[idx];
  assign dst = paq[AP-1 -: ANCHO_ID];
  assign consumir = concedido && (dst == identificadorFPGA || dst == DIFUSION);
  assign reenviar = concedido && dst != identificadorFPGA;
  assign push = reenviar && !colaLlena;
  assign mascara_push = ~(N'(1) << idx);
  cola_reenvio #(.ANCHO(AP + N), .PROFUNDIDAD(PROFUNDIDAD_COLA)) u_cola (
    .clk(reloj), .rst(reinicio), .push(push), .pop(pop), .dato({paq, mascara_push}),
    .cabeza(cabeza), .full(colaLlena), .empty(vacia)
  );
  always_comb begin
    pop = estado == REPOSO && !vacia;
    estado_sig = pop ? ESPERA
               : estado == ESPERA && (mascara & transmisorOcupado) == '0 ? INICIO
               : estado == INICIO ? REPOSO : estado;
  end
  assign iniciarTransmision = estado == INICIO ? mascara : '0;
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      pendiente <= '0;
      ptr <= '0;
      estado <= REPOSO;
      mascara <= '0;
      datoTransmitir <= '0;
      datoConsumido <= '0;
      datoConsumidoValido <= 1'b0;
      cantidadContadorPaquetes <= '0;
      cantidadContadorPaquetesProcesados <= '0;
      cantidadContadorPaquetesDescartados <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (recepcionFinalizada[i] && !sobre[i]) begin
          pendiente[i] <= 1'b1;
          pend_dato[i] <= datoRecibido[i*AP +: AP];
        end else if (concedido && idx == PW'(i)) pendiente[i] <= 1'b0;
      if (concedido) ptr <= idx == PW'(N - 1) ? '0 : idx + PW'(1);
      estado <= estado_sig;
      if (pop) {datoTransmitir, mascara} <= cabeza;
      datoConsumidoValido <= consumir;
      if (consumir) datoConsumido <= paq[ANCHO_CARGA-1:0];
      cantidadContadorPaquetes <= sat(cantidadContadorPaquetes, int'(consumir));
      cantidadContadorPaquetesProcesados <= sat(cantidadContadorPaquetesProcesados, int'(concedido));
      cantidadContadorPaquetesDescartados <= sat(cantidadContadorPaquetesDescartados,
        $countones(sobre) + int'(reenviar && colaLlena));
    end
  end
endmodule

// File: tb/tb_procesador_paquetes_n.sv
// tb_procesador_paquetes_n: randomized + directed scoreboard bench for procesador_paquetes_n
module tb_procesador_paquetes_n;
  localparam int N = 3;
  localparam int D = 4;
  logic reloj = 1'b0, reinicio = 1'b1;
  logic [3:0] id = 4'h5;
  logic [2:0] rf = '0, busy = '0;
  logic [23:0] dr = '0;
  logic [2:0] start;
  logic [7:0] dtx, c_cons, c_proc, c_desc;
  logic [3:0] dcons;
  logic dvalid, llena;

  procesador_paquetes_n dut (
    .reloj(reloj), .reinicio(reinicio), .identificadorFPGA(id),
    .recepcionFinalizada(rf), .datoRecibido(dr), .transmisorOcupado(busy),
    .iniciarTransmision(start), .datoTransmitir(dtx), .datoConsumido(dcons),
    .datoConsumidoValido(dvalid), .cantidadContadorPaquetes(c_cons),
    .cantidadContadorPaquetesProcesados(c_proc),
    .cantidadContadorPaquetesDescartados(c_desc), .colaLlena(llena)
  );

  always #5 reloj = ~reloj;

  // Reference model: pending slots, a queue for the forward FIFO, and a transmit slot
  bit m_pend[N];
  logic [7:0] m_pp[N];
  int m_ptr, m_stage, m_cons, m_proc, m_desc;
  logic [10:0] m_fifo[$];
  logic [10:0] m_cur;
  bit m_valid;
  logic [3:0] cons_q[$];
  logic [10:0] tx_q[$];
  int vectors = 0, miscompares = 0;
  bit run = 1'b0;

  function automatic int sat(input int v);
    return v >= 255 ? 255 : v + 1;
  endfunction

  function void step();
    int g;
    bit full0, do_push;
    logic [7:0] p;
    logic [2:0] mk;
    logic [10:0] nuevo;
    if (reinicio) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0; m_stage = 0; m_cons = 0; m_proc = 0; m_desc = 0; m_valid = 1'b0; m_cur = '0;
      m_fifo.delete(); cons_q.delete(); tx_q.delete();
      return;
    end
    full0 = m_fifo.size() == D;
    do_push = 1'b0;
    nuevo = '0;
    m_valid = 1'b0;
    g = -1;
    for (int j = 0; j < N; j++)
      if (g < 0 && m_pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
    if (g >= 0) begin
      p = m_pp[g];
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % N;
      m_proc = sat(m_proc);
      if (p[7:4] == id || p[7:4] == 4'hF) begin
        m_cons = sat(m_cons);
        cons_q.push_back(p[3:0]);
        m_valid = 1'b1;
      end
      if (p[7:4] != id) begin
        if (full0) m_desc = sat(m_desc);
        else begin
          mk = ~(3'b001 << g);
          nuevo = {p, mk};
          do_push = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (rf[i]) begin
        if (m_pend[i]) m_desc = sat(m_desc);
        else begin
          m_pend[i] = 1'b1;
          m_pp[i] = dr[i*8 +: 8];
        end
      end
    if (m_stage == 0) begin
      if (m_fifo.size() > 0) begin
        m_cur = m_fifo.pop_front();
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      if ((m_cur[2:0] & busy) == 3'b000) m_stage = 2;
    end else m_stage = 0;
    if (do_push) begin
      m_fifo.push_back(nuevo);
      tx_q.push_back(nuevo);
    end
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function void fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endfunction

  logic [10:0] e;
  always begin
    @(posedge reloj);
    #1;
    if (run) begin
      chk("valid", 32'(dvalid), 32'(m_valid));
      if (dvalid) begin
        if (cons_q.size() == 0) fail("consume_extra");
        else chk("payload", 32'(dcons), 32'(cons_q.pop_front()));
      end
      chk("start", 32'(start), 32'(m_stage == 2 ? m_cur[2:0] : 3'b000));
      if (start != 3'b000) begin
        if (tx_q.size() == 0) fail("tx_extra");
        else begin
          e = tx_q.pop_front();
          chk("tx_pkt", 32'(dtx), 32'(e[10:3]));
          chk("tx_mask", 32'(start), 32'(e[2:0]));
        end
      end
      chk("consumed", 32'(c_cons), 32'(m_cons));
      chk("processed", 32'(c_proc), 32'(m_proc));
      chk("dropped", 32'(c_desc), 32'(m_desc));
      chk("full", 32'(llena), 32'(m_fifo.size() == D));
    end
  end

  task automatic cyc(input logic [2:0] p, input logic [23:0] d, input logic [2:0] b, input logic r);
    @(negedge reloj);
    rf = p; dr = d; busy = b; reinicio = r;
    step();
  endtask

  task automatic idle(input int n, input logic [2:0] b);
    for (int i = 0; i < n; i++) cyc(3'b000, 24'h0, b, 1'b0);
  endtask

  function automatic logic [7:0] rnd_pkt();
    int r = $urandom_range(0, 3);
    return {r == 0 ? 4'h5 : r == 1 ? 4'hF : 4'($urandom), 4'($urandom)};
  endfunction

  initial begin
    cyc(3'b000, 24'h0, 3'b000, 1'b1);
    run = 1'b1;
    cyc(3'b000, 24'h0, 3'b000, 1'b1);
    cyc(3'b001, 24'h00005A, 3'b000, 1'b0);
    idle(6, 3'b000);
    cyc(3'b010, 24'h003700, 3'b000, 1'b0);
    idle(8, 3'b000);
    cyc(3'b111, 24'h535251, 3'b000, 1'b0);
    idle(6, 3'b000);
    cyc(3'b101, 24'h530051, 3'b000, 1'b0);
    idle(6, 3'b000);
    cyc(3'b100, 24'hF00000, 3'b000, 1'b0);
    idle(8, 3'b000);
    for (int k = 0; k < 6; k++) cyc(3'b001, {16'h0, 8'h30 + 8'(k)}, 3'b111, 1'b0);
    idle(5, 3'b111);
    idle(25, 3'b000);
    cyc(3'b001, 24'h000037, 3'b111, 1'b0);
    idle(4, 3'b111);
    cyc(3'b000, 24'h0, 3'b111, 1'b1);
    idle(8, 3'b000);
    for (int c = 0; c < 900; c++)
      cyc({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
          {rnd_pkt(), rnd_pkt(), rnd_pkt()}, 3'($urandom) & 3'($urandom),
          $urandom_range(0, 399) == 0);
    cyc(3'b000, 24'h0, 3'b000, 1'b1);
    for (int c = 0; c < 300; c++) cyc(3'b111, {rnd_pkt(), rnd_pkt(), rnd_pkt()}, 3'($urandom), 1'b0);
    for (int c = 0; c < 200 && (m_fifo.size() > 0 || m_stage != 0 || m_pend[0] || m_pend[1] || m_pend[2]); c++)
      idle(1, 3'b000);
    idle(3, 3'b000);
    chk("tx_drained", 32'(tx_q.size()), 32'd0);
    chk("consume_drained", 32'(cons_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
